// File: rtl/slon5_stage_ctrl.sv
// Sequencer for the iterative slon5 stage datapath: accepts one operand, steps STAGE_NUM stages,
// waits DP_LAT cycles for the result, then holds it on a valid/ready output until accepted.
module slon5_stage_ctrl #(
  parameter int WORD_WIDTH = 16,
  parameter int STAGE_NUM  = 8,
  parameter int DP_LAT     = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         ref_clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_WIDTH-1:0]        in_data,
  input  logic                         abort,
  output logic [WORD_WIDTH-1:0]        dp_data,
  output logic                         dp_en,
  output logic [$clog2(STAGE_NUM)-1:0] dp_stage,
  output logic                         dp_first,
  output logic                         dp_last,
  input  logic [WORD_WIDTH-1:0]        dp_res,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_WIDTH-1:0]        out_data,
  output logic [CNT_WIDTH-1:0]         dnum,
  output logic                         busy
);

  localparam int SW = $clog2(STAGE_NUM);
  localparam int WW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(STAGE_NUM - 1);
  localparam logic [WW-1:0] WAIT_LOAD  = WW'(DP_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] stage;
  logic [WW-1:0] wait_cnt;

  always_ff @(posedge ref_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid)            state_nxt = RUN;
        RUN:     if (stage == LAST_STAGE) state_nxt = DRAIN;
        DRAIN:   if (wait_cnt == '0)      state_nxt = OUT;
        OUT:     if (out_ready)           state_nxt = IDLE;
        default:                          state_nxt = IDLE;
      endcase
    end
  end

  // in_ready is gated by abort so an aborting cycle never accepts an operand.
  always_comb begin
    in_ready  = (state == IDLE) && !abort;
    dp_en     = (state == RUN);
    dp_first  = (state == RUN) && (stage == '0);
    dp_last   = (state == RUN) && (stage == LAST_STAGE);
    out_valid = (state == OUT);
    busy      = (state != IDLE);
  end

  assign dp_stage = stage;

  // stage is only non-zero inside RUN, so the table address is always in range.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      stage    <= '0;
      wait_cnt <= '0;
      dp_data  <= '0;
      out_data <= '0;
      dnum     <= '0;
    end else if (abort) begin
      stage    <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dp_data <= in_data;
            stage   <= '0;
          end
        end
        RUN: begin
          if (stage == LAST_STAGE) begin
            stage    <= '0;
            wait_cnt <= WAIT_LOAD;
          end else begin
            stage <= stage + SW'(1);
          end
        end
        DRAIN: begin
          if (wait_cnt == '0) out_data <= dp_res;
          else                wait_cnt <= wait_cnt - WW'(1);
        end
        OUT: begin
          if (out_ready) dnum <= dnum + CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slon5_stage_ctrl.sv
// Bench for slon5_stage_ctrl: lockstep comparison against a transaction-phase model plus scenario checks.
module tb_slon5_stage_ctrl;

  logic ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  logic        rst, in_valid, abort, out_ready;
  logic [15:0] in_data, dp_res;

  logic        a_in_ready, a_dp_en, a_dp_first, a_dp_last, a_out_valid, a_busy;
  logic [15:0] a_dp_data, a_out_data, a_dnum;
  logic [2:0]  a_dp_stage;

  logic        b_in_ready, b_dp_en, b_dp_first, b_dp_last, b_out_valid, b_busy;
  logic [15:0] b_dp_data, b_out_data;
  logic [3:0]  b_dnum;
  logic [2:0]  b_dp_stage;

  slon5_stage_ctrl dut_a (
    .ref_clk(ref_clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .abort(abort), .dp_data(a_dp_data), .dp_en(a_dp_en), .dp_stage(a_dp_stage),
    .dp_first(a_dp_first), .dp_last(a_dp_last), .dp_res(dp_res), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .dnum(a_dnum), .busy(a_busy)
  );

  slon5_stage_ctrl #(.WORD_WIDTH(16), .STAGE_NUM(5), .DP_LAT(1), .CNT_WIDTH(4)) dut_b (
    .ref_clk(ref_clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .abort(abort), .dp_data(b_dp_data), .dp_en(b_dp_en), .dp_stage(b_dp_stage),
    .dp_first(b_dp_first), .dp_last(b_dp_last), .dp_res(dp_res), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .dnum(b_dnum), .busy(b_busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit sel    = 1'b0;

  // Reference model: a transaction is "active" from the cycle after its handshake;
  // m_t counts cycles since that handshake.
  bit          m_act;
  int          m_t, m_S, m_L, m_cw, m_dnum;
  logic [15:0] m_data, m_out;

  function automatic logic [63:0] obs_vec();
    if (!sel)
      return {7'd0, a_in_ready, a_dp_en, a_dp_first, a_dp_last, a_out_valid, a_busy,
              a_dp_stage, a_dp_data, a_out_data, a_dnum};
    else
      return {7'd0, b_in_ready, b_dp_en, b_dp_first, b_dp_last, b_out_valid, b_busy,
              b_dp_stage, b_dp_data, b_out_data, 12'd0, b_dnum};
  endfunction

  function automatic logic [63:0] exp_vec();
    logic en;
    logic [2:0] st;
    en = m_act && (m_t <= m_S);
    st = en ? 3'(m_t - 1) : 3'd0;
    return {7'd0, (!m_act && !abort), en, (en && m_t == 1), (en && m_t == m_S),
            (m_act && m_t > m_S + m_L), m_act, st, m_data, m_out, 16'(m_dnum)};
  endfunction

  task automatic tick();
    if (rst) begin
      m_act = 0; m_t = 0; m_data = '0; m_out = '0; m_dnum = 0;
    end else if (abort) begin
      m_act = 0;
    end else if (!m_act) begin
      if (in_valid) begin
        m_act = 1; m_t = 1; m_data = in_data;
      end
    end else begin
      if (m_t == m_S + m_L) m_out = dp_res;
      if (m_t > m_S + m_L && out_ready) begin
        m_dnum = (m_dnum + 1) % (1 << m_cw);
        m_act  = 0;
      end
      m_t++;
    end
    @(posedge ref_clk);
    #1;
    dp_res = 16'($urandom);
    cyc++;
  endtask

  task automatic drive(input logic iv, input logic [15:0] id, input logic ab, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    abort     = ab;
    out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
    checks++;
    if ({a_in_ready, a_dp_en, a_dp_first, a_dp_last, a_out_valid, a_busy} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=100000",
               {a_in_ready, a_dp_en, a_dp_first, a_dp_last, a_out_valid, a_busy});
    end
    checks++;
    if ({a_dp_stage, a_dp_data, a_out_data, a_dnum} !== 51'd0) begin
      errors++;
      $display("FAIL reset_values got=%h want=0", {a_dp_stage, a_dp_data, a_out_data, a_dnum});
    end
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL lockstep_reset cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_single();
    logic [15:0] res_save;
    int d0;
    d0 = m_dnum;
    res_save = '0;
    for (int i = 0; i < 16; i++) begin
      drive(i == 0, 16'h1234, 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL lockstep_single cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        checks++;
        if ({a_dp_en, a_dp_first, a_dp_last, a_dp_stage, a_dp_data} !== {3'b110, 3'd0, 16'h1234}) begin
          errors++;
          $display("FAIL single_first got=%h want=%h",
                   {a_dp_en, a_dp_first, a_dp_last, a_dp_stage, a_dp_data}, {3'b110, 3'd0, 16'h1234});
        end
      end
      if (i == 8) begin
        checks++;
        if ({a_dp_en, a_dp_first, a_dp_last, a_dp_stage} !== {3'b101, 3'd7}) begin
          errors++;
          $display("FAIL single_last got=%b want=%b",
                   {a_dp_en, a_dp_first, a_dp_last, a_dp_stage}, {3'b101, 3'd7});
        end
      end
      if (i == 10) res_save = dp_res;
      if (i == 11) begin
        checks++;
        if ({a_out_valid, a_out_data} !== {1'b1, res_save}) begin
          errors++;
          $display("FAIL single_out got=%h want=%h", {a_out_valid, a_out_data}, {1'b1, res_save});
        end
      end
      if (i == 12) begin
        checks++;
        if ({a_in_ready, a_dnum} !== {1'b1, 16'(d0 + 1)}) begin
          errors++;
          $display("FAIL single_done got=%h want=%h", {a_in_ready, a_dnum}, {1'b1, 16'(d0 + 1)});
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int vcnt, d0;
    bit done;
    logic ordy;
    logic [15:0] held;
    vcnt = 0; done = 0; held = '0;
    d0 = m_dnum;
    for (int i = 0; i < 40 && !done; i++) begin
      ordy = (vcnt == 5);
      drive(1'b1, 16'($urandom), 1'b0, ordy);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL lockstep_bp cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (a_out_valid) begin
        if (vcnt == 0) held = a_out_data;
        else begin
          checks++;
          if ({a_out_data, a_dnum, a_in_ready} !== {held, 16'(d0), 1'b0}) begin
            errors++;
            $display("FAIL bp_hold got=%h want=%h", {a_out_data, a_dnum, a_in_ready}, {held, 16'(d0), 1'b0});
          end
        end
        vcnt++;
        if (ordy) done = 1;
      end
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    checks++;
    if (!done || {a_dnum, a_in_ready, a_out_valid} !== {16'(d0 + 1), 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL bp_accept done=%0d got=%h want=%h", done, {a_dnum, a_in_ready, a_out_valid},
               {16'(d0 + 1), 1'b1, 1'b0});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int last, words, d0;
    logic [15:0] nxt;
    last = -1; words = 0; nxt = '0;
    d0 = m_dnum;
    for (int i = 0; i < 10 * 12 + 14; i++) begin
      drive(words < 10, nxt, 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL lockstep_b2b cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (in_valid && a_in_ready) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 12) begin
            errors++;
            $display("FAIL b2b_period got=%0d want=12", cyc - last);
          end
        end
        last = cyc;
        nxt++;
        words++;
      end
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    checks++;
    if ({a_dnum, 16'(words)} !== {16'(d0 + 10), 16'd10}) begin
      errors++;
      $display("FAIL b2b_count got dnum=%0d words=%0d want dnum=%0d words=10", a_dnum, words, 16'(d0 + 10));
    end
    tick();
  endtask

  task automatic test_abort();
    int d0;
    bit hit;
    d0 = m_dnum;
    for (int i = 0; i < 7; i++) begin
      drive(i == 0, 16'($urandom), i == 4, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL lockstep_abort cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (i == 5) begin
        checks++;
        if ({a_dp_en, a_in_ready, a_busy, a_out_valid, a_dp_stage, a_dnum} !== {4'b0100, 3'd0, 16'(d0)}) begin
          errors++;
          $display("FAIL abort_run got=%h want=%h", {a_dp_en, a_in_ready, a_busy, a_out_valid, a_dp_stage, a_dnum},
                   {4'b0100, 3'd0, 16'(d0)});
        end
      end
      tick();
    end
    drive(1'b1, 16'hBEEF, 1'b1, 1'b1);
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_ready got=%b want=0", a_in_ready);
    end
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    checks++;
    if (obs_vec() !== exp_vec() || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_accept got=%h want=%h", obs_vec(), exp_vec());
    end
    tick();
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      drive(i == 0, 16'($urandom), 1'b0, 1'b1);
      if (a_out_valid) begin
        drive(1'b0, 16'h0, 1'b1, 1'b1);
        hit = 1;
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL lockstep_abort_out cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    checks++;
    if (!hit || {a_out_valid, a_busy, a_dnum} !== {2'b00, 16'(d0)}) begin
      errors++;
      $display("FAIL abort_out hit=%0d got=%h want=%h", hit, {a_out_valid, a_busy, a_dnum}, {2'b00, 16'(d0)});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      rst = (i == 9);
      drive(i == 0, 16'($urandom), 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL lockstep_rstmid cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    checks++;
    if (obs_vec() !== {7'd0, 6'b100000, 51'd0}) begin
      errors++;
      $display("FAIL rstmid_values got=%h want=%h", obs_vec(), {7'd0, 6'b100000, 51'd0});
    end
    tick();
    for (int i = 0; i < 14; i++) begin
      drive(i == 0, 16'($urandom), 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL lockstep_rstmid2 cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    checks++;
    if (a_dnum !== 16'd1) begin
      errors++;
      $display("FAIL rstmid_complete got=%0d want=1", a_dnum);
    end
    tick();
  endtask

  task automatic test_params();
    int last, words, first_hs;
    bit seen;
    sel = 1'b1; m_S = 5; m_L = 1; m_cw = 4;
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    last = -1; words = 0; first_hs = -1; seen = 0;
    for (int i = 0; i < 17 * 8 + 10; i++) begin
      drive(words < 17, 16'($urandom), 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL lockstep_params cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (b_out_valid && !seen && first_hs >= 0) begin
        seen = 1;
        checks++;
        if (cyc - first_hs !== 7) begin
          errors++;
          $display("FAIL params_out_latency got=%0d want=7", cyc - first_hs);
        end
      end
      if (in_valid && b_in_ready) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 8) begin
            errors++;
            $display("FAIL params_period got=%0d want=8", cyc - last);
          end
        end
        if (first_hs < 0) first_hs = cyc;
        last = cyc;
        words++;
      end
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    checks++;
    if ({b_dnum, 8'(words)} !== {4'd1, 8'd17}) begin
      errors++;
      $display("FAIL params_wrap got dnum=%0d words=%0d want dnum=1 words=17", b_dnum, words);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    in_data = '0; dp_res = '0;
    m_act = 0; m_t = 0; m_S = 8; m_L = 2; m_cw = 16; m_dnum = 0;
    m_data = '0; m_out = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slon5_stage_ctrl.md
Name: slon5_stage_ctrl

Overview:
- Sequencer for the iterative slon5 stage datapath.
- Accepts one operand word per transaction over a valid/ready handshake.
- Drives the datapath through STAGE_NUM stage iterations, supplying the stage index and first/last flags that index KTable/STable.
- Waits the fixed datapath latency, captures the result, presents it on a valid/ready output and counts completed words (dnum).

Parameters:
- WORD_WIDTH, 16: operand/result width.
- STAGE_NUM, 8: stage iterations per word; legal range >= 2.
- DP_LAT, 2: datapath latency, in cycles, from the last stage strobe to a valid dp_res; legal range >= 1.
- CNT_WIDTH, 16: width of the completed-word counter.

Ports:
- ref_clk, in, 1: system clock.
- rst, in, 1: synchronous reset, active-high.
- in_valid, in, 1: operand valid.
- in_ready, out, 1: controller can accept an operand.
- in_data, in, WORD_WIDTH: operand.
- abort, in, 1: synchronous abort of the current transaction.
- dp_data, out, WORD_WIDTH: latched operand to the datapath.
- dp_en, out, 1: stage iteration strobe.
- dp_stage, out, $clog2(STAGE_NUM): stage index; used as the KTable/STable address.
- dp_first, out, 1: marks stage 0.
- dp_last, out, 1: marks stage STAGE_NUM-1.
- dp_res, in, WORD_WIDTH: datapath result.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- out_data, out, WORD_WIDTH: registered result.
- dnum, out, CNT_WIDTH: completed-word count.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- All outputs are registered or decoded from registered state.
- On rst (priority over everything): state IDLE, in_ready=1, dp_en/dp_first/dp_last/out_valid/busy=0, dp_stage=0, dp_data=0, out_data=0, dnum=0.
- FSM states: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - in_ready=1.
  - Handshake in_valid&in_ready at cycle T: dp_data<=in_data, stage<=0, go to RUN.
- RUN (cycles T+1 .. T+STAGE_NUM):
  - dp_en=1; dp_stage=0..STAGE_NUM-1, incrementing each cycle.
  - dp_first=1 only at stage 0; dp_last=1 only at stage STAGE_NUM-1.
  - After stage STAGE_NUM-1: go to DRAIN and load the wait counter.
- DRAIN:
  - dp_en=0; lasts DP_LAT cycles.
  - dp_res is sampled at the clock edge ending cycle T+STAGE_NUM+DP_LAT, into out_data.
  - Then go to OUT.
- OUT:
  - out_valid=1 from cycle T+STAGE_NUM+DP_LAT+1; out_data is held stable while out_valid=1.
  - out_valid&out_ready: dnum<=dnum+1 (wraps modulo 2^CNT_WIDTH), go to IDLE; in_ready=1 the next cycle.
- in_ready=0 in RUN, DRAIN and OUT. There is no overlap of transactions; minimum period is STAGE_NUM+DP_LAT+2 cycles.
- dp_data is held constant through RUN and DRAIN. in_data changes after the handshake have no effect.
- abort=1 in any state:
  - Next cycle: IDLE, dp_en/dp_first/dp_last/out_valid=0, dp_stage=0, dnum unchanged, out_data unchanged.
  - abort has priority over a simultaneous out handshake: that word is not counted.
  - abort in IDLE concurrent with in_valid: the operand is not accepted (in_ready is forced 0 while abort=1).
- rst mid-transaction: identical to reset values; any pending result is discarded.
- dp_stage width: $clog2(STAGE_NUM). No out-of-range index is ever driven, including for non-power-of-two STAGE_NUM.

Test Plan:
1. Defaults; in_data=16'h1234 accepted at T=10, out_ready=1 -> dp_en high cycles 11..18 with dp_stage 0..7; dp_first at 11, dp_last at 18; out_data = dp_res value driven at cycle 20; out_valid at 21; dnum=1 at 22; in_ready=1 at 22.
2. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_data stable for 5 cycles; dnum increments only on the accepting edge; in_valid held high is not accepted until IDLE.
3. Back-to-back: in_valid constantly 1, out_ready=1, sw-style incrementing in_data (0,1,2,...) -> one handshake every 12 cycles; outputs in order; dnum=10 after 10 words.
4. Abort in RUN at stage 3 -> dp_en=0 next cycle, no out_valid, dnum unchanged, in_ready=1 next cycle. Abort coincident with out_valid&out_ready -> dnum unchanged.
5. Reset mid-DRAIN -> every output at its reset value the following cycle; the next transaction completes normally.
6. Wrap and non-default parameters: CNT_WIDTH=4, 17 words -> dnum=1. STAGE_NUM=5, DP_LAT=1 -> dp_stage 0..4, out_valid at T+7.
